// File: rtl/br_retire_queue.sv
// In-order queue of in-flight conditional branches. It retires up to two
// resolved branches per cycle and raises a one-cycle history recovery on a mispredict.
module br_retire_queue #(
   parameter int BRQ_DEPTH = 16,
   parameter int BRQ_BITS  = 4,
   parameter int BHR_BITS  = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          id_dispatch_num,
   input  logic                id_valid_cond0,
   input  logic                id_valid_cond1,
   input  logic [63:0]         id_NPC0,
   input  logic [63:0]         id_NPC1,
   input  logic [BHR_BITS-1:0] id_bhr0,
   input  logic [BHR_BITS-1:0] id_bhr1,
   input  logic                id_pred_taken0,
   input  logic                id_pred_taken1,
   output logic [BRQ_BITS-1:0] id_brq_tag0,
   output logic [BRQ_BITS-1:0] id_brq_tag1,
   output logic                brq_full,
   input  logic                ex_resolve_valid0,
   input  logic                ex_resolve_valid1,
   input  logic [BRQ_BITS-1:0] ex_resolve_tag0,
   input  logic [BRQ_BITS-1:0] ex_resolve_tag1,
   input  logic                ex_actual_taken0,
   input  logic                ex_actual_taken1,
   output logic [1:0]          rob_retire_num,
   output logic                rob_retire_cond0,
   output logic                rob_retire_cond1,
   output logic [63:0]         rob_retire_NPC0,
   output logic [63:0]         rob_retire_NPC1,
   output logic [BHR_BITS-1:0] rob_retire_BHR0,
   output logic [BHR_BITS-1:0] rob_retire_BHR1,
   output logic                rob_actual_taken0,
   output logic                rob_actual_taken1,
   output logic                recover_cond,
   output logic [BHR_BITS-1:0] recover_bhr
);

   typedef enum logic {NORMAL, RECOVER} state_t;
   state_t state, state_nxt;

   logic [BRQ_DEPTH-1:0] valid, resolved, mispred, pred_tk, act_tk;
   logic [63:0]          npc [BRQ_DEPTH];
   logic [BHR_BITS-1:0]  bhr [BRQ_DEPTH];

   logic [BRQ_BITS:0]   head, tail, used;
   logic [BRQ_BITS-1:0] h0, h1, t0, t1;
   logic                run, want0, want1, take, alloc0, alloc1;
   logic                res0, res1, slot0, slot1, mis0, mis1, flush;
   logic [1:0]          ret_cnt, alloc_cnt;
   logic [BHR_BITS-1:0] fix_bhr;

   assign used     = tail - head;
   assign brq_full = used[BRQ_BITS] | (&used[BRQ_BITS-1:0]);
   assign run      = (state == NORMAL);

   assign h0 = head[BRQ_BITS-1:0];
   assign h1 = h0 + 1'b1;
   assign t0 = tail[BRQ_BITS-1:0];

   assign want0 = (id_dispatch_num != 2'd0) && id_valid_cond0;
   assign want1 = id_dispatch_num[1] && id_valid_cond1;
   assign t1    = want0 ? t0 + 1'b1 : t0;

   assign id_brq_tag0 = t0;
   assign id_brq_tag1 = t1;

   // Older branches retire first; a mispredicting slot 0 blocks slot 1.
   assign slot0 = run && valid[h0] && resolved[h0];
   assign slot1 = slot0 && !mispred[h0] && valid[h1] && resolved[h1];
   assign mis0  = slot0 && mispred[h0];
   assign mis1  = slot1 && mispred[h1];
   assign flush = mis0 || mis1;

   // Wrong-path dispatch in the flush cycle is dropped with the rest.
   assign take   = run && !brq_full && !flush;
   assign alloc0 = want0 && take;
   assign alloc1 = want1 && take;

   assign res0 = run && ex_resolve_valid0 && valid[ex_resolve_tag0];
   assign res1 = run && ex_resolve_valid1 && valid[ex_resolve_tag1];

   assign ret_cnt   = {1'b0, slot0} + {1'b0, slot1};
   assign alloc_cnt = {1'b0, alloc0} + {1'b0, alloc1};

   always_comb begin
      fix_bhr = {bhr[h1][BHR_BITS-2:0], act_tk[h1]};
      if (mis0)
         fix_bhr = {bhr[h0][BHR_BITS-2:0], act_tk[h0]};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         NORMAL:  if (flush) state_nxt = RECOVER;
         RECOVER: state_nxt = NORMAL;
         default: state_nxt = NORMAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= NORMAL;
         head              <= '0;
         tail              <= '0;
         valid             <= '0;
         resolved          <= '0;
         mispred           <= '0;
         rob_retire_num    <= '0;
         rob_retire_cond0  <= 1'b0;
         rob_retire_cond1  <= 1'b0;
         rob_retire_NPC0   <= '0;
         rob_retire_NPC1   <= '0;
         rob_retire_BHR0   <= '0;
         rob_retire_BHR1   <= '0;
         rob_actual_taken0 <= 1'b0;
         rob_actual_taken1 <= 1'b0;
         recover_cond      <= 1'b0;
         recover_bhr       <= '0;
      end else begin
         state             <= state_nxt;
         head              <= head + {{(BRQ_BITS-1){1'b0}}, ret_cnt};
         rob_retire_num    <= ret_cnt;
         rob_retire_cond0  <= slot0;
         rob_retire_cond1  <= slot1;
         rob_retire_NPC0   <= slot0 ? npc[h0] : '0;
         rob_retire_NPC1   <= slot1 ? npc[h1] : '0;
         rob_retire_BHR0   <= slot0 ? bhr[h0] : '0;
         rob_retire_BHR1   <= slot1 ? bhr[h1] : '0;
         rob_actual_taken0 <= slot0 & act_tk[h0];
         rob_actual_taken1 <= slot1 & act_tk[h1];
         recover_cond      <= (state == RECOVER);
         if (res0) begin
            resolved[ex_resolve_tag0] <= 1'b1;
            mispred[ex_resolve_tag0]  <= ex_actual_taken0 ^ pred_tk[ex_resolve_tag0];
         end
         if (res1) begin
            resolved[ex_resolve_tag1] <= 1'b1;
            mispred[ex_resolve_tag1]  <= ex_actual_taken1 ^ pred_tk[ex_resolve_tag1];
         end
         if (alloc0) begin
            valid[t0]    <= 1'b1;
            resolved[t0] <= 1'b0;
            mispred[t0]  <= 1'b0;
         end
         if (alloc1) begin
            valid[t1]    <= 1'b1;
            resolved[t1] <= 1'b0;
            mispred[t1]  <= 1'b0;
         end
         if (slot0) valid[h0] <= 1'b0;
         if (slot1) valid[h1] <= 1'b0;
         if (flush) begin
            valid       <= '0;
            tail        <= head + {{(BRQ_BITS-1){1'b0}}, ret_cnt};
            recover_bhr <= fix_bhr;
         end else begin
            tail <= tail + {{(BRQ_BITS-1){1'b0}}, alloc_cnt};
         end
      end
   end

   // Payload needs no reset; valid bits guard every read.
   always_ff @(posedge clock) begin
      if (res0) act_tk[ex_resolve_tag0] <= ex_actual_taken0;
      if (res1) act_tk[ex_resolve_tag1] <= ex_actual_taken1;
      if (alloc0) begin
         npc[t0]     <= id_NPC0;
         bhr[t0]     <= id_bhr0;
         pred_tk[t0] <= id_pred_taken0;
      end
      if (alloc1) begin
         npc[t1]     <= id_NPC1;
         bhr[t1]     <= id_bhr1;
         pred_tk[t1] <= id_pred_taken1;
      end
   end

endmodule

// File: tb/tb_br_retire_queue.sv
// Directed bench for br_retire_queue: dispatch, resolve, in-order retire,
// mispredict recovery, full/wrap handling and reset during recovery.
module tb_br_retire_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  id_dispatch_num;
   logic        id_valid_cond0, id_valid_cond1;
   logic [63:0] id_NPC0, id_NPC1;
   logic [5:0]  id_bhr0, id_bhr1;
   logic        id_pred_taken0, id_pred_taken1;
   logic [3:0]  id_brq_tag0, id_brq_tag1;
   logic        brq_full;
   logic        ex_resolve_valid0, ex_resolve_valid1;
   logic [3:0]  ex_resolve_tag0, ex_resolve_tag1;
   logic        ex_actual_taken0, ex_actual_taken1;
   logic [1:0]  rob_retire_num;
   logic        rob_retire_cond0, rob_retire_cond1;
   logic [63:0] rob_retire_NPC0, rob_retire_NPC1;
   logic [5:0]  rob_retire_BHR0, rob_retire_BHR1;
   logic        rob_actual_taken0, rob_actual_taken1;
   logic        recover_cond;
   logic [5:0]  recover_bhr;

   int checks = 0;
   int errors = 0;

   br_retire_queue dut (
      .clock(clock), .reset(reset),
      .id_dispatch_num(id_dispatch_num),
      .id_valid_cond0(id_valid_cond0), .id_valid_cond1(id_valid_cond1),
      .id_NPC0(id_NPC0), .id_NPC1(id_NPC1),
      .id_bhr0(id_bhr0), .id_bhr1(id_bhr1),
      .id_pred_taken0(id_pred_taken0), .id_pred_taken1(id_pred_taken1),
      .id_brq_tag0(id_brq_tag0), .id_brq_tag1(id_brq_tag1),
      .brq_full(brq_full),
      .ex_resolve_valid0(ex_resolve_valid0), .ex_resolve_valid1(ex_resolve_valid1),
      .ex_resolve_tag0(ex_resolve_tag0), .ex_resolve_tag1(ex_resolve_tag1),
      .ex_actual_taken0(ex_actual_taken0), .ex_actual_taken1(ex_actual_taken1),
      .rob_retire_num(rob_retire_num),
      .rob_retire_cond0(rob_retire_cond0), .rob_retire_cond1(rob_retire_cond1),
      .rob_retire_NPC0(rob_retire_NPC0), .rob_retire_NPC1(rob_retire_NPC1),
      .rob_retire_BHR0(rob_retire_BHR0), .rob_retire_BHR1(rob_retire_BHR1),
      .rob_actual_taken0(rob_actual_taken0), .rob_actual_taken1(rob_actual_taken1),
      .recover_cond(recover_cond), .recover_bhr(recover_bhr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      id_dispatch_num   = 2'd0;
      id_valid_cond0    = 1'b0;
      id_valid_cond1    = 1'b0;
      id_NPC0           = 64'd0;
      id_NPC1           = 64'd0;
      id_bhr0           = 6'd0;
      id_bhr1           = 6'd0;
      id_pred_taken0    = 1'b0;
      id_pred_taken1    = 1'b0;
      ex_resolve_valid0 = 1'b0;
      ex_resolve_valid1 = 1'b0;
      ex_resolve_tag0   = 4'd0;
      ex_resolve_tag1   = 4'd0;
      ex_actual_taken0  = 1'b0;
      ex_actual_taken1  = 1'b0;
   endtask

   task automatic disp(input logic [1:0] num, input logic v0, input logic v1,
                       input logic [63:0] n0, input logic [63:0] n1,
                       input logic [5:0] b0, input logic [5:0] b1,
                       input logic p0, input logic p1);
      id_dispatch_num = num;
      id_valid_cond0  = v0;
      id_valid_cond1  = v1;
      id_NPC0         = n0;
      id_NPC1         = n1;
      id_bhr0         = b0;
      id_bhr1         = b1;
      id_pred_taken0  = p0;
      id_pred_taken1  = p1;
      #1;
   endtask

   task automatic res(input logic v0, input logic [3:0] g0, input logic a0,
                      input logic v1, input logic [3:0] g1, input logic a1);
      ex_resolve_valid0 = v0;
      ex_resolve_tag0   = g0;
      ex_actual_taken0  = a0;
      ex_resolve_valid1 = v1;
      ex_resolve_tag1   = g1;
      ex_actual_taken1  = a1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      chk("rst_num", 64'(rob_retire_num), 64'd0);
      chk("rst_cond0", 64'(rob_retire_cond0), 64'd0);
      chk("rst_rcv", 64'(recover_cond), 64'd0);
      chk("rst_rbhr", 64'(recover_bhr), 64'd0);
      chk("rst_full", 64'(brq_full), 64'd0);
      chk("rst_tag0", 64'(id_brq_tag0), 64'd0);
      reset = 1'b0;

      // Two branches, both predicted correctly
      disp(2'd2, 1'b1, 1'b1, 64'h100, 64'h104, 6'h00, 6'h01, 1'b0, 1'b1);
      chk("s1_tag0", 64'(id_brq_tag0), 64'd0);
      chk("s1_tag1", 64'(id_brq_tag1), 64'd1);
      chk("s1_full", 64'(brq_full), 64'd0);
      tick();
      idle();
      res(1'b1, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1);
      tick();
      idle();
      chk("s1_noearly", 64'(rob_retire_num), 64'd0);
      tick();
      chk("s1_num", 64'(rob_retire_num), 64'd2);
      chk("s1_cond0", 64'(rob_retire_cond0), 64'd1);
      chk("s1_cond1", 64'(rob_retire_cond1), 64'd1);
      chk("s1_npc0", rob_retire_NPC0, 64'h100);
      chk("s1_npc1", rob_retire_NPC1, 64'h104);
      chk("s1_bhr0", 64'(rob_retire_BHR0), 64'h00);
      chk("s1_bhr1", 64'(rob_retire_BHR1), 64'h01);
      chk("s1_tk0", 64'(rob_actual_taken0), 64'd0);
      chk("s1_tk1", 64'(rob_actual_taken1), 64'd1);
      chk("s1_rcv", 64'(recover_cond), 64'd0);
      tick();
      chk("s1_idle", 64'(rob_retire_num), 64'd0);
      chk("s1_rcv2", 64'(recover_cond), 64'd0);

      // Lane 0 not a branch: lane 1 takes the tail tag
      disp(2'd2, 1'b0, 1'b1, 64'h0, 64'h200, 6'h00, 6'h05, 1'b0, 1'b1);
      chk("s2_tag1", 64'(id_brq_tag1), 64'd2);
      tick();
      idle();
      #1;
      chk("s2_single", 64'(id_brq_tag0), 64'd3);

      // Out-of-order resolve; same-tag resolve where port 1 wins
      disp(2'd1, 1'b1, 1'b0, 64'h300, 64'h0, 6'h0A, 6'h00, 1'b0, 1'b0);
      chk("s3_tag0", 64'(id_brq_tag0), 64'd3);
      tick();
      idle();
      res(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      idle();
      tick();
      chk("s3_wait", 64'(rob_retire_num), 64'd0);
      res(1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b1);
      tick();
      idle();
      chk("s3_wait2", 64'(rob_retire_num), 64'd0);
      tick();
      chk("s3_num", 64'(rob_retire_num), 64'd2);
      chk("s3_npc0", rob_retire_NPC0, 64'h200);
      chk("s3_npc1", rob_retire_NPC1, 64'h300);
      chk("s3_bhr0", 64'(rob_retire_BHR0), 64'h05);
      chk("s3_bhr1", 64'(rob_retire_BHR1), 64'h0A);
      chk("s3_tk0", 64'(rob_actual_taken0), 64'd1);
      chk("s3_rcv", 64'(recover_cond), 64'd0);

      // Mispredict at retire with a resolved younger branch behind it
      disp(2'd2, 1'b1, 1'b1, 64'h400, 64'h404, 6'h2A, 6'h15, 1'b1, 1'b0);
      chk("s4_tag0", 64'(id_brq_tag0), 64'd4);
      tick();
      idle();
      res(1'b1, 4'd4, 1'b0, 1'b1, 4'd5, 1'b0);
      tick();
      idle();
      disp(2'd1, 1'b1, 1'b0, 64'h999, 64'h0, 6'h3F, 6'h00, 1'b1, 1'b0);
      tick();
      idle();
      #1;
      chk("s4_num", 64'(rob_retire_num), 64'd1);
      chk("s4_cond0", 64'(rob_retire_cond0), 64'd1);
      chk("s4_cond1", 64'(rob_retire_cond1), 64'd0);
      chk("s4_npc0", rob_retire_NPC0, 64'h400);
      chk("s4_npc1", rob_retire_NPC1, 64'h0);
      chk("s4_bhr0", 64'(rob_retire_BHR0), 64'h2A);
      chk("s4_tk0", 64'(rob_actual_taken0), 64'd0);
      chk("s4_rcv_early", 64'(recover_cond), 64'd0);
      chk("s4_rbhr", 64'(recover_bhr), 64'h14);
      chk("s4_tail", 64'(id_brq_tag0), 64'd5);
      disp(2'd1, 1'b1, 1'b0, 64'hAAA, 64'h0, 6'h01, 6'h00, 1'b0, 1'b0);
      res(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      idle();
      #1;
      chk("s4_rcv", 64'(recover_cond), 64'd1);
      chk("s4_rcv_bhr", 64'(recover_bhr), 64'h14);
      chk("s4_rcv_num", 64'(rob_retire_num), 64'd0);
      chk("s4_rcv_cond0", 64'(rob_retire_cond0), 64'd0);
      chk("s4_rcv_tail", 64'(id_brq_tag0), 64'd5);
      tick();
      chk("s4_rcv_off", 64'(recover_cond), 64'd0);
      chk("s4_rbhr_hold", 64'(recover_bhr), 64'h14);
      chk("s4_post_num", 64'(rob_retire_num), 64'd0);
      tick();
      chk("s4_no_young", 64'(rob_retire_num), 64'd0);

      // Fill 15 entries starting at tag 5, wrapping past 15
      for (int i = 0; i < 7; i++) begin
         disp(2'd2, 1'b1, 1'b1, 64'(32'h1000 + 8*i), 64'(32'h1004 + 8*i),
              6'(2*i), 6'(2*i+1), 1'b0, 1'b0);
         chk("s5_tag0", 64'(id_brq_tag0), 64'((5 + 2*i) % 16));
         chk("s5_tag1", 64'(id_brq_tag1), 64'((6 + 2*i) % 16));
         tick();
      end
      idle();
      #1;
      chk("s5_notfull", 64'(brq_full), 64'd0);
      disp(2'd1, 1'b1, 1'b0, 64'h1038, 64'h0, 6'd14, 6'd0, 1'b0, 1'b0);
      chk("s5_tag_last", 64'(id_brq_tag0), 64'd3);
      tick();
      idle();
      #1;
      chk("s5_full", 64'(brq_full), 64'd1);
      chk("s5_tailw", 64'(id_brq_tag0), 64'd4);
      disp(2'd2, 1'b1, 1'b1, 64'hDEAD, 64'hBEEF, 6'h3F, 6'h3F, 1'b1, 1'b1);
      tick();
      idle();
      #1;
      chk("s5_drop_tail", 64'(id_brq_tag0), 64'd4);
      chk("s5_drop_full", 64'(brq_full), 64'd1);
      res(1'b1, 4'd5, 1'b0, 1'b1, 4'd6, 1'b0);
      tick();
      idle();
      tick();
      chk("s5_num", 64'(rob_retire_num), 64'd2);
      chk("s5_npc0", rob_retire_NPC0, 64'h1000);
      chk("s5_npc1", rob_retire_NPC1, 64'h1004);
      chk("s5_unfull", 64'(brq_full), 64'd0);
      res(1'b1, 4'd7, 1'b0, 1'b1, 4'd8, 1'b0);
      tick();
      idle();
      tick();
      chk("s5_npc0b", rob_retire_NPC0, 64'h1008);
      chk("s5_npc1b", rob_retire_NPC1, 64'h100C);
      chk("s5_bhr1b", 64'(rob_retire_BHR1), 64'd3);

      // Mispredict, then reset during the recovery cycle
      res(1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0);
      tick();
      idle();
      tick();
      chk("s6_num", 64'(rob_retire_num), 64'd1);
      chk("s6_npc0", rob_retire_NPC0, 64'h1010);
      chk("s6_rbhr", 64'(recover_bhr), 64'h09);
      reset = 1'b1;
      tick();
      chk("s6_rcv", 64'(recover_cond), 64'd0);
      chk("s6_num0", 64'(rob_retire_num), 64'd0);
      chk("s6_cond0", 64'(rob_retire_cond0), 64'd0);
      chk("s6_npc_clr", rob_retire_NPC0, 64'd0);
      chk("s6_rbhr_clr", 64'(recover_bhr), 64'd0);
      chk("s6_full", 64'(brq_full), 64'd0);
      chk("s6_tag0", 64'(id_brq_tag0), 64'd0);
      reset = 1'b0;
      tick();
      chk("s6_rcv2", 64'(recover_cond), 64'd0);
      disp(2'd1, 1'b1, 1'b0, 64'h500, 64'h0, 6'h00, 6'h00, 1'b0, 1'b0);
      chk("s6_empty_tag", 64'(id_brq_tag0), 64'd0);
      tick();
      idle();
      #1;
      chk("s6_alloc", 64'(id_brq_tag0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
